uart_word_tx: RTL
=================

# uart_word_tx

Serial transmitter that sends 16-bit accelerometer words to the host as two 8N1 UART bytes. It sits downstream of the accelerometer FIFO manager. It samples that block's `DataOut`, serialises the word MSB byte first, and returns the one-cycle `wordComplete` pulse that advances the manager's X→Y→Z→FFFF axis sequence. It is the consumer end of the `DataOut`/`wordComplete` handshake.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal minimum is 2.
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset. Sampled on `posedge clk`.
- `Tx_Enable`  in  1  level. While high, words are streamed back-to-back.
- `DataIn`  in  16  word to send. Driven by the FIFO manager's `DataOut`.
- `o_Tx_Serial`  out  1  UART line. Idle level is high.
- `o_Tx_Active`  out  1  high from the first START cycle through the last STOP cycle of a word.
- `wordComplete`  out  1  one-cycle pulse after the second byte's stop bit.

## Operation
- States: IDLE, SETTLE, START, DATA, STOP, DONE.
- Internal registers:
  - `word_q[15:0]`: latched word.
  - `byte_sel`: 0 selects `word_q[15:8]`, 1 selects `word_q[7:0]`.
  - `bit_idx[2:0]`: data bit index.
  - `clk_cnt`: counts 0..`CLKS_PER_BIT`-1.
  - `settle_cnt`: 1 bit.
- IDLE:
  - Line is high.
  - When `Tx_Enable`=1, go to SETTLE with `settle_cnt`=0.
- SETTLE:
  - Lasts exactly 2 cycles.
  - This absorbs the manager's one-cycle `Axis_Counter`→`DataOut` register latency.
  - On the edge ending the 2nd cycle: `word_q` <= `DataIn`, `byte_sel`<=0, then go to START.
- START:
  - Line is 0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx`=0.
- DATA:
  - Line is the selected byte's bit `bit_idx`, sent LSB first.
  - Each bit is held `CLKS_PER_BIT` cycles.
  - After bit 7, go to STOP.
- STOP:
  - Line is 1 for `CLKS_PER_BIT` cycles.
  - If `byte_sel`=0: set `byte_sel`=1 and go to START. There is no extra idle between bytes.
  - Otherwise go to DONE.
- DONE:
  - Lasts 1 cycle, line high, `wordComplete`=1.
  - Next state is SETTLE if `Tx_Enable`=1, else IDLE.
- `Tx_Enable` is sampled only in IDLE and DONE. Deasserting it mid-word does not abort: the word finishes and `wordComplete` still pulses.
- `DataIn` is sampled only at the end of SETTLE. Changes at any other time have no effect on the word in flight.
- `clk_cnt` resets to 0 at every bit boundary. No counter wraps inside a bit.

## Timing
- Reset values: `o_Tx_Serial`=1, `o_Tx_Active`=0, `wordComplete`=0, state=IDLE. All counters are 0 and `word_q`=0.
- Reset mid-frame: on the cycle after `rst` is sampled high, the line is 1. No `wordComplete` is issued for the aborted word.
- Latency from IDLE with `Tx_Enable` rising:
  - 1 cycle to enter SETTLE.
  - 2 SETTLE cycles.
  - The START bit appears on the line in cycle 4 after `Tx_Enable` is sampled.
- Word duration: 20×`CLKS_PER_BIT` cycles of line activity (2 × {start, 8 data, stop}).
- Steady-state period with `Tx_Enable` held high: 20×`CLKS_PER_BIT` + 3 cycles. This is 1 DONE + 2 SETTLE.
- `wordComplete`:
  - High for exactly one cycle.
  - That cycle immediately follows the last STOP cycle of byte 2.
  - It is never asserted in any other state.
- `o_Tx_Active`:
  - Rises in the first START cycle of byte 1.
  - Falls in the DONE cycle.
  - It stays high across the byte-1 STOP → byte-2 START boundary.
- All outputs are registered and glitch-free. `o_Tx_Serial` changes only on `posedge clk`.
- `rst` and `Tx_Enable` asserted in the same cycle: `rst` wins and the state stays IDLE.

## Test plan
- Reset: assert `rst` for 3 cycles, then hold `Tx_Enable`=0 for 100 cycles → `o_Tx_Serial`=1, `o_Tx_Active`=0, `wordComplete`=0 throughout.
- Single word, `CLKS_PER_BIT`=4, `DataIn`=16'hA55A, pulse `Tx_Enable` for 1 cycle:
  - Line bit sequence: 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1. Each bit is 4 cycles wide.
  - START begins 4 cycles after the enable sample.
  - `wordComplete` pulses once, 80 cycles after the START edge.
  - The block returns to IDLE.
- Streaming with the FIFO manager model: X=16'h0123, Y=16'h4567, Z=16'h89AB, `Tx_Enable` held high, `CLKS_PER_BIT`=4.
  - Decoded bytes: 01 23 45 67 89 AB FF FF 01 23.
  - `wordComplete` pulses are spaced exactly 83 cycles apart.
- Mid-word `DataIn` change and `Tx_Enable` drop:
  - Stimulus: change `DataIn` 16'h1111→16'h2222 and drop `Tx_Enable` during byte-1 DATA.
  - Required: 16'h1111 is sent intact, `wordComplete` pulses once, then IDLE with no second word.
- Reset mid-frame: assert `rst` during byte-2 bit 3 → the line is high on the next cycle, no `wordComplete`, and a fresh enable sends a full correct word.
- `CLKS_PER_BIT`=2 boundary: word 16'hFFFF → two frames of 0 followed by nine 1s, each bit exactly 2 cycles. Period is 43 cycles with enable held.

Source files
------------

// File: rtl/uart_word_tx_if.sv
// Word handshake between the accelerometer FIFO manager and the UART word transmitter.
// The manager (master) supplies the word and enable; the transmitter (slave) drives the line.
interface uart_word_tx_if;
    logic        Tx_Enable;
    logic [15:0] DataIn;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        wordComplete;

    modport master (
        output Tx_Enable,
        output DataIn,
        input  o_Tx_Serial,
        input  o_Tx_Active,
        input  wordComplete
    );

    modport slave (
        input  Tx_Enable,
        input  DataIn,
        output o_Tx_Serial,
        output o_Tx_Active,
        output wordComplete
    );
endinterface

// File: rtl/uart_word_tx.sv
// Sends a 16-bit word as two 8N1 UART bytes, MSB byte first, and pulses
// wordComplete once the second stop bit has finished.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          rst,
    uart_word_tx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [15:0]   word_q, word_d;
    logic          byte_sel_q, byte_sel_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic          settle_cnt_q, settle_cnt_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;

    logic          last_tick;
    logic [7:0]    cur_byte;

    assign last_tick = (clk_cnt_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_sel_d   = byte_sel_q;
        bit_idx_d    = bit_idx_q;
        clk_cnt_d    = clk_cnt_q;
        settle_cnt_d = settle_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Tx_Enable) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = 1'b0;
                end
            end
            S_SETTLE: begin
                // Two cycles let the manager's DataOut register catch up.
                if (settle_cnt_q) begin
                    word_d     = bus.DataIn;
                    byte_sel_d = 1'b0;
                    clk_cnt_d  = '0;
                    state_d    = S_START;
                end else begin
                    settle_cnt_d = 1'b1;
                end
            end
            S_START: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                settle_cnt_d = 1'b0;
                state_d      = bus.Tx_Enable ? S_SETTLE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    assign cur_byte = byte_sel_d ? word_d[7:0] : word_d[15:8];

    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            S_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            S_DATA: begin
                serial_d = cur_byte[bit_idx_d];
                active_d = 1'b1;
            end
            S_STOP: begin
                active_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            byte_sel_q   <= 1'b0;
            bit_idx_q    <= '0;
            clk_cnt_q    <= '0;
            settle_cnt_q <= 1'b0;
            serial_q     <= 1'b1;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_sel_q   <= byte_sel_d;
            bit_idx_q    <= bit_idx_d;
            clk_cnt_q    <= clk_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            serial_q     <= serial_d;
            active_q     <= active_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_Tx_Serial  = serial_q;
    assign bus.o_Tx_Active  = active_q;
    assign bus.wordComplete = done_q;
endmodule
